// File: rtl/simd_widen.sv
// simd_widen: packed-SIMD widening unit.
//
// Takes one MAX_WIDTH operand of packed SEW-wide elements and emits two MAX_WIDTH
// beats of 2*SEW-wide elements. Beat 0 widens the low half of the operand and beat 1
// widens the high half.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   valid_i/ready_o input operand handshake
//   sew             one-hot source width; bit k selects MAX_WIDTH>>k bits, k>=1 legal
//   high            1: source goes in the upper half of the element; 0: extend it
//   signed_i        sign (1) or zero (0) extension, used only when high=0
//   opA             packed source elements
//   valid_o/ready_i output beat handshake
//   result          widened beat
//   last_o          current beat is beat 1
//   err_o           current beat belongs to an illegal-sew operation
//
// Optional feature: define SIMD_WIDEN_ERR_EN to latch an error bit for illegal sew and
// drive err_o on both beats. Without it err_o is tied low. Illegal sew always gives
// all-zero beats.
module simd_widen #(
  parameter int unsigned MIN_WIDTH = 8,
  parameter int unsigned MAX_WIDTH = 64,
  parameter int unsigned SEW_WIDTH = $clog2(MAX_WIDTH / MIN_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [SEW_WIDTH-1:0] sew,
  input  logic                 high,
  input  logic                 signed_i,
  input  logic [MAX_WIDTH-1:0] opA,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [MAX_WIDTH-1:0] result,
  output logic                 last_o,
  output logic                 err_o
);

  localparam int unsigned HalfWidth = MAX_WIDTH / 2;

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1} state_e;

  state_e                 state_q, state_d;
  logic [MAX_WIDTH-1:0]   opa_q;
  logic [SEW_WIDTH-1:0]   sew_q;
  logic                   high_q;
  logic                   signed_q;
  logic                   accept;

  assign accept = valid_i && ready_o;

  // Illegal when sew is not one-hot or selects the full datapath width (bit 0).
  function automatic logic sew_illegal(input logic [SEW_WIDTH-1:0] s);
    logic onehot;
    onehot = (s != '0) && ((s & (s - SEW_WIDTH'(1))) == '0);
    return !onehot || s[0];
  endfunction

  // FSM next state and handshake outputs.
  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    last_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready_o = 1'b1;
        if (valid_i) state_d = StBeat0;
      end
      StBeat0: begin
        valid_o = 1'b1;
        if (ready_i) state_d = StBeat1;
      end
      StBeat1: begin
        valid_o = 1'b1;
        last_o  = 1'b1;
        ready_o = ready_i;
        if (ready_i) state_d = valid_i ? StBeat0 : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      opa_q    <= '0;
      sew_q    <= '0;
      high_q   <= 1'b0;
      signed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opa_q    <= opA;
        sew_q    <= sew;
        high_q   <= high;
        signed_q <= signed_i;
      end
    end
  end

  // Source half for the current beat.
  logic [HalfWidth-1:0] half;
  assign half = (state_q == StBeat1) ? opa_q[MAX_WIDTH-1:HalfWidth] : opa_q[HalfWidth-1:0];

  // One widened candidate per legal element width; cand[0] is the illegal full-width code.
  logic [SEW_WIDTH-1:0][MAX_WIDTH-1:0] cand;
  assign cand[0] = '0;

  for (genvar k = 1; k < SEW_WIDTH; k++) begin : g_sew
    localparam int unsigned E = MAX_WIDTH >> k;
    localparam int unsigned N = HalfWidth / E;
    for (genvar i = 0; i < N; i++) begin : g_el
      logic [E-1:0] src;
      assign src = half[i*E +: E];
      assign cand[k][i*2*E +: 2*E] = high_q   ? {src, {E{1'b0}}} :
                                     signed_q ? {{E{src[E-1]}}, src} :
                                                {{E{1'b0}}, src};
    end
  end

  always_comb begin
    result = '0;
    if (!sew_illegal(sew_q)) begin
      for (int k = 1; k < SEW_WIDTH; k++) begin
        if (sew_q[k]) result = cand[k];
      end
    end
  end

`ifdef SIMD_WIDEN_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= sew_illegal(sew);
    end
  end

  assign err_o = err_q && valid_o;
`else
  assign err_o = 1'b0;
`endif

endmodule
